// File: rtl/x_axis_pkg.sv
// Shared types and constants for the X-axis polygon-mirror speed controller.
package x_axis_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SPINUP   = 2'd1,
      REGULATE = 2'd2,
      FAULT    = 2'd3
   } state_e;

   // motor_ctrl_signal bit positions
   localparam int MCS_PWM = 0;
   localparam int MCS_EN  = 1;

   localparam int CNT_W_DEF = 20;
   localparam int PWM_W_DEF = 8;

endpackage

// File: rtl/x_axis_motor_controller_if.sv
// Control/status bundle between the motor controller and its host.
interface x_axis_motor_controller_if #(
   parameter int CNT_W = 20,
   parameter int PWM_W = 8
);
   logic             enable;
   logic [CNT_W-1:0] target_period;
   logic             feedback_clk;
   logic [1:0]       motor_ctrl_signal;
   logic             line_start;
   logic             locked;
   logic             fault;
   logic [CNT_W-1:0] measured_period;
   logic [PWM_W-1:0] duty;

   modport master (
      output enable, target_period, feedback_clk,
      input  motor_ctrl_signal, line_start, locked, fault, measured_period, duty
   );

   modport slave (
      input  enable, target_period, feedback_clk,
      output motor_ctrl_signal, line_start, locked, fault, measured_period, duty
   );
endinterface

// File: rtl/x_axis_period_meter.sv
// Tachometer front end: synchronises feedback_clk, detects facet edges and
// measures the facet period with a saturating cycle counter.
module x_axis_period_meter #(
   parameter int CNT_W        = 20,
   parameter int STALL_CYCLES = 2**20 - 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,          // held while the controller is idle
   input  logic             feedback_clk,
   output logic             fb_edge,
   output logic             period_valid,   // fb_edge carrying a complete period
   output logic             stall,
   output logic [CNT_W-1:0] count,          // period being accumulated right now
   output logic [CNT_W-1:0] measured_period
);

   // [0],[1] synchronise, [2] is the delayed copy for edge detection
   logic [2:0] sync_pipe;
   logic       first_edge;

   // synchroniser and registered rising-edge detect
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_pipe <= '0;
         fb_edge   <= 1'b0;
      end else begin
         sync_pipe <= {sync_pipe[1:0], feedback_clk};
         fb_edge   <= sync_pipe[1] & ~sync_pipe[2];
      end
   end

   // period counter: reload to 1 on each edge so the captured value is the edge-to-edge distance
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count      <= '0;
         first_edge <= 1'b1;
      end else if (fb_edge) begin
         count      <= CNT_W'(1);
         first_edge <= 1'b0;
      end else if (count != '1) begin
         count      <= count + CNT_W'(1);
      end
   end

   // capture a period only when the counter spanned a whole facet
   always_ff @(posedge clk) begin
      if (reset)
         measured_period <= '0;
      else if (period_valid)
         measured_period <= count;
   end

   assign period_valid = fb_edge & ~first_edge & ~clear;
   assign stall        = (count >= CNT_W'(STALL_CYCLES));

endmodule

// File: rtl/x_axis_motor_controller.sv
// Closed-loop speed controller for the polygon-mirror motor: spin-up, duty
// regulation toward target_period, lock detection, stall watchdog and PWM.
module x_axis_motor_controller
   import x_axis_pkg::*;
#(
   parameter int CNT_W        = CNT_W_DEF,
   parameter int PWM_W        = PWM_W_DEF,
   parameter int TOL          = 16,
   parameter int DEADBAND     = 4,
   parameter int LOCK_COUNT   = 16,
   parameter int STALL_CYCLES = 2**20 - 1
) (
   input  logic                      clk,
   input  logic                      reset,
   x_axis_motor_controller_if.slave  bus
);

   localparam int LW = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W:0]  TOL_X  = (CNT_W+1)'(TOL);
   localparam logic [CNT_W:0]  DB_X   = (CNT_W+1)'(DEADBAND);
   localparam logic [LW-1:0]   LOCK_N = LW'(LOCK_COUNT);

   state_e           state_q, state_n;
   logic [PWM_W-1:0] duty_q, duty_n;
   logic [LW-1:0]    lock_q, lock_n;
   logic [PWM_W-1:0] pwm_cnt;
   logic             fb_edge, period_valid, stall;
   logic [CNT_W-1:0] count;
   logic             drv_en;

   // one extra bit so target+TOL cannot wrap and target-DEADBAND clamps at 0
   logic [CNT_W:0] meas_x, tgt_x, hi_tol, lo_tol, hi_db, lo_db;
   logic           in_tol;

   x_axis_period_meter #(
      .CNT_W        (CNT_W),
      .STALL_CYCLES (STALL_CYCLES)
   ) u_meter (
      .clk             (clk),
      .reset           (reset),
      .clear           (state_q == IDLE),
      .feedback_clk    (bus.feedback_clk),
      .fb_edge         (fb_edge),
      .period_valid    (period_valid),
      .stall           (stall),
      .count           (count),
      .measured_period (bus.measured_period)
   );

   // window arithmetic on the period completing this cycle
   always_comb begin
      meas_x = {1'b0, count};
      tgt_x  = {1'b0, bus.target_period};
      hi_tol = tgt_x + TOL_X;
      lo_tol = (tgt_x > TOL_X) ? tgt_x - TOL_X : '0;
      hi_db  = tgt_x + DB_X;
      lo_db  = (tgt_x > DB_X) ? tgt_x - DB_X : '0;
      in_tol = (meas_x <= hi_tol) && (meas_x >= lo_tol);
   end

   // state, duty and lock counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         duty_q  <= '0;
         lock_q  <= '0;
      end else begin
         state_q <= state_n;
         duty_q  <= duty_n;
         lock_q  <= lock_n;
      end
   end

   // next state plus next duty/lock values
   always_comb begin
      state_n = state_q;
      duty_n  = duty_q;
      lock_n  = lock_q;
      case (state_q)
         IDLE: begin
            duty_n = '0;
            lock_n = '0;
            if (bus.enable) begin
               state_n = SPINUP;
               duty_n  = '1;
            end
         end
         SPINUP: begin
            duty_n = '1;
            if (!bus.enable) begin
               state_n = IDLE;
               duty_n  = '0;
            end else if (period_valid && (meas_x <= hi_tol)) begin
               state_n = REGULATE;
            end else if (!fb_edge && stall) begin
               state_n = FAULT;
               duty_n  = '0;
            end
         end
         REGULATE: begin
            if (!bus.enable) begin
               state_n = IDLE;
               duty_n  = '0;
               lock_n  = '0;
            end else if (period_valid) begin
               if (meas_x > hi_db) begin
                  if (duty_q != '1) duty_n = duty_q + PWM_W'(1);
               end else if (meas_x < lo_db) begin
                  if (duty_q != '0) duty_n = duty_q - PWM_W'(1);
               end
               if (in_tol)
                  lock_n = (lock_q == LOCK_N) ? lock_q : lock_q + LW'(1);
               else
                  lock_n = '0;
            end else if (!fb_edge && stall) begin
               state_n = FAULT;
               duty_n  = '0;
               lock_n  = '0;
            end
         end
         FAULT: begin
            duty_n = '0;
            lock_n = '0;
            if (!bus.enable) state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            duty_n  = '0;
            lock_n  = '0;
         end
      endcase
   end

   // free-running PWM frame counter
   always_ff @(posedge clk) begin
      if (reset) pwm_cnt <= '0;
      else       pwm_cnt <= pwm_cnt + PWM_W'(1);
   end

   assign drv_en                         = (state_q == SPINUP) || (state_q == REGULATE);
   assign bus.motor_ctrl_signal[MCS_EN]  = drv_en;
   assign bus.motor_ctrl_signal[MCS_PWM] = (pwm_cnt < duty_q) & drv_en;
   assign bus.duty                       = duty_q;
   assign bus.locked                     = (lock_q == LOCK_N);
   assign bus.line_start                 = fb_edge & bus.locked;
   assign bus.fault                      = (state_q == FAULT);

endmodule
